stopwatch_seg_display: RTL and testbench

Downstream consumer of stopwatch_top. Takes the binary minutes/seconds/status outputs and drives a 4-digit multiplexed common-anode 7-segment display showing MM.SS. Contains a sequential binary-to-BCD converter, a digit-scan refresh counter and a pause-blink controller. Sits between stopwatch_top and the board display pins.

---
 rtl/stopwatch_pkg.sv | 43 ++++
 rtl/stopwatch_seg_display_bin2bcd_seq.sv | 83 ++++++++
 rtl/stopwatch_seg_display.sv | 149 ++++++++++++++
 tb/tb_stopwatch_seg_display.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display path.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package stopwatch_pkg;

   // Status encodings driven by stopwatch_top; 2'b11 is handled like idle.
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;

   // Largest value each field can show on two digits.
   localparam int MAX_MIN = 99;
   localparam int MAX_SEC = 59;

   localparam int NUM_DIGITS = 4;

   // Sequential binary-to-BCD converter states.
   typedef enum logic [1:0] {
      CV_IDLE = 2'd0,
      CV_CONV = 2'd1,
      CV_DONE = 2'd2
   } conv_state_t;

   // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; blank for non-BCD.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/stopwatch_seg_display_bin2bcd_seq.sv
// Two parallel 7-bit binary to 2-digit BCD converters sharing one double-dabble FSM.
// Latency: start accepted in IDLE, 7 CONV cycles, results valid while done is high (1 cycle).
// Backpressure: start is ignored while busy; caller must hold off until busy drops.
//
// Ports: clk, rst_n (async active-low); start with bin_a/bin_b operands;
//        busy (CONV or DONE), done (1-cycle, results valid); bcd_a/bcd_b {tens, ones}.
module bin2bcd_seq
   import stopwatch_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [6:0] bin_a,
   input  logic [6:0] bin_b,
   output logic       busy,
   output logic       done,
   output logic [7:0] bcd_a,
   output logic [7:0] bcd_b
);

   conv_state_t state;
   conv_state_t state_nxt;

   // Shift registers laid out as {tens, ones, binary}; BCD grows in from the right.
   logic [14:0] sr_a;
   logic [14:0] sr_b;
   logic [2:0]  step;

   // One double-dabble iteration: correct nibbles that would exceed 9 after
   // doubling, then shift one binary bit into the BCD field.
   function automatic logic [14:0] dd_step(input logic [14:0] v);
      logic [14:0] t;
      t = v;
      if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
      if (t[10:7]  >= 4'd5) t[10:7]  = t[10:7]  + 4'd3;
      return {t[13:0], 1'b0};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= CV_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CV_IDLE: if (start) state_nxt = CV_CONV;
         CV_CONV: if (step == 3'd6) state_nxt = CV_DONE;
         CV_DONE: state_nxt = CV_IDLE;
         default: state_nxt = CV_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_a <= '0;
         sr_b <= '0;
         step <= '0;
      end else begin
         case (state)
            CV_IDLE: begin
               if (start) begin
                  sr_a <= {8'd0, bin_a};
                  sr_b <= {8'd0, bin_b};
               end
               step <= '0;
            end
            CV_CONV: begin
               sr_a <= dd_step(sr_a);
               sr_b <= dd_step(sr_b);
               step <= step + 3'd1;
            end
            default: ;
         endcase
      end
   end

   assign busy  = (state != CV_IDLE);
   assign done  = (state == CV_DONE);
   assign bcd_a = sr_a[14:7];
   assign bcd_b = sr_b[14:7];

endmodule

// File: rtl/stopwatch_seg_display.sv
// Drives a 4-digit multiplexed common-anode 7-segment display as MM.SS from stopwatch_top.
// Latency: input change to digits 9 cycles (17 worst case); an/seg/dp follow scan index by 1 cycle.
// Backpressure: none; inputs are sampled continuously, changes mid-conversion are picked up afterwards.
//
// Ports: clk, rst_n (async active-low); minutes[7:0], seconds[5:0], status[1:0] from stopwatch_top;
//        an[3:0] active-low digit enables (an[0] rightmost), seg[6:0] active-low {g..a},
//        dp active-low decimal point, digits[15:0] registered BCD {mt, mo, st, so}.
module stopwatch_seg_display
   import stopwatch_pkg::*;
#(
   parameter int REFRESH_DIV = 1000,
   parameter int BLINK_SCANS = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            minutes,
   input  logic [5:0]            seconds,
   input  logic [1:0]            status,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [15:0]           digits
);

   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

   // ---------------- clamp and change detection ----------------
   logic [6:0] min_clamp;
   logic [6:0] sec_clamp;
   logic [6:0] snap_min;
   logic [6:0] snap_sec;
   logic       pending;
   logic       conv_start;
   logic       conv_busy;
   logic       conv_done;
   logic [7:0] bcd_min;
   logic [7:0] bcd_sec;

   assign min_clamp = (minutes > 8'(MAX_MIN)) ? 7'(MAX_MIN) : minutes[6:0];
   assign sec_clamp = (seconds > 6'(MAX_SEC)) ? 7'(MAX_SEC) : {1'b0, seconds};

   // pending forces one conversion after reset even if inputs equal the zero snapshot.
   assign conv_start = !conv_busy &&
                       (pending || (min_clamp != snap_min) || (sec_clamp != snap_sec));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= 1'b1;
         snap_min <= '0;
         snap_sec <= '0;
      end else if (conv_start) begin
         pending  <= 1'b0;
         snap_min <= min_clamp;
         snap_sec <= sec_clamp;
      end
   end

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (conv_start),
      .bin_a (min_clamp),
      .bin_b (sec_clamp),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd_a (bcd_min),
      .bcd_b (bcd_sec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         digits <= '0;
      else if (conv_done) digits <= {bcd_min, bcd_sec};
   end

   // ---------------- digit scan ----------------
   logic [RW-1:0] ref_cnt;
   logic [1:0]    scan_idx;
   logic          ref_tc;
   logic          scan_wrap;

   assign ref_tc    = (ref_cnt == RW'(REFRESH_DIV - 1));
   assign scan_wrap = ref_tc && (scan_idx == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_cnt  <= '0;
         scan_idx <= '0;
      end else if (ref_tc) begin
         ref_cnt  <= '0;
         scan_idx <= scan_idx + 2'd1;
      end else begin
         ref_cnt  <= ref_cnt + RW'(1);
      end
   end

   // ---------------- pause blink ----------------
   logic          paused;
   logic [BW-1:0] blink_cnt;
   logic          blink_on;

   assign paused = (status == ST_PAUSE);

   // Held in the on phase outside PAUSED so every pause starts visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (!paused) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (scan_wrap) begin
         if (blink_cnt == BW'(BLINK_SCANS - 1)) begin
            blink_cnt <= '0;
            blink_on  <= !blink_on;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   // ---------------- output registers ----------------
   logic [3:0] cur_nib;

   always_comb begin
      cur_nib = digits[3:0];
      case (scan_idx)
         2'd0: cur_nib = digits[3:0];
         2'd1: cur_nib = digits[7:4];
         2'd2: cur_nib = digits[11:8];
         2'd3: cur_nib = digits[15:12];
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= '1;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= (paused && !blink_on) ? '1 : ~(NUM_DIGITS'(1) << scan_idx);
         seg <= seg7(cur_nib);
         // Decimal point sits after the minutes-ones digit and only lights while running.
         dp  <= !((scan_idx == 2'd2) && (status == ST_RUN));
      end
   end

endmodule

// File: tb/tb_stopwatch_seg_display.sv
module tb_stopwatch_seg_display;

   localparam int RD = 4;
   localparam int BS = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  minutes = 8'd0;
   logic [5:0]  seconds = 6'd0;
   logic [1:0]  status = 2'b00;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [15:0] digits;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   stopwatch_seg_display #(.REFRESH_DIV(RD), .BLINK_SCANS(BS)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .minutes (minutes),
      .seconds (seconds),
      .status  (status),
      .an      (an),
      .seg     (seg),
      .dp      (dp),
      .digits  (digits)
   );

   always #5 clk = ~clk;

   // Segment table written out from the digit shapes.
   logic [6:0] lut [0:15];
   initial begin
      lut[0] = 7'h40; lut[1] = 7'h79; lut[2] = 7'h24; lut[3] = 7'h30;
      lut[4] = 7'h19; lut[5] = 7'h12; lut[6] = 7'h02; lut[7] = 7'h78;
      lut[8] = 7'h00; lut[9] = 7'h10;
      for (int i = 10; i < 16; i++) lut[i] = 7'h7F;
   end

   // ---------------- behavioural model ----------------
   // Time-based view: edges since reset release, conversion completes 8 edges
   // after it is accepted, blink phase is the parity of completed scan wraps / BS.
   int          m_t, m_free_at, m_write_at, m_wraps, m_idx, m_cm, m_cs;
   bit          m_pending, m_phase_on;
   int          m_snap_min, m_snap_sec;
   logic [15:0] m_digits, m_pend;
   logic [3:0]  m_nib;
   logic [3:0]  exp_an = 4'hF;
   logic [6:0]  exp_seg = 7'h7F;
   logic        exp_dp = 1'b1;
   logic [15:0] exp_digits = 16'h0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_t = 0; m_free_at = 1; m_write_at = -1; m_wraps = 0;
         m_pending = 1'b1; m_phase_on = 1'b1;
         m_snap_min = 0; m_snap_sec = 0; m_digits = 16'h0; m_pend = 16'h0;
         exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_digits = 16'h0;
      end else begin
         m_t++;
         m_idx = ((m_t - 1) / RD) % 4;
         m_nib = m_digits[m_idx*4 +: 4];
         exp_seg = lut[m_nib];
         exp_an = (status == 2'b10 && !m_phase_on) ? 4'hF : ~(4'b0001 << m_idx);
         exp_dp = (m_idx == 2 && status == 2'b01) ? 1'b0 : 1'b1;
         if (status != 2'b10) begin
            m_wraps = 0;
            m_phase_on = 1'b1;
         end else if (m_t % (4 * RD) == 0) begin
            m_wraps++;
            m_phase_on = ((m_wraps / BS) % 2 == 0);
         end
         if (m_t == m_write_at) m_digits = m_pend;
         if (m_t >= m_free_at) begin
            m_cm = (minutes > 99) ? 99 : int'(minutes);
            m_cs = (seconds > 59) ? 59 : int'(seconds);
            if (m_pending || m_cm != m_snap_min || m_cs != m_snap_sec) begin
               m_pending = 1'b0;
               m_snap_min = m_cm;
               m_snap_sec = m_cs;
               m_pend = {4'(m_cm / 10), 4'(m_cm % 10), 4'(m_cs / 10), 4'(m_cs % 10)};
               m_write_at = m_t + 8;
               m_free_at = m_t + 9;
            end
         end
         exp_digits = m_digits;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         checks++;
         if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || digits !== exp_digits) begin
            errors++;
            $display("FAIL model t=%0d an %h exp %h seg %h exp %h dp %b exp %b digits %h exp %h",
                     m_t, an, exp_an, seg, exp_seg, dp, exp_dp, digits, exp_digits);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   logic [3:0] an_seq [0:3];
   logic [6:0] seg_seq [0:3];
   int n, dp_low, dp_bad, blanks;

   initial begin
      an_seq[0] = 4'hE; an_seq[1] = 4'hD; an_seq[2] = 4'hB; an_seq[3] = 4'h7;
      seg_seq[0] = 7'h19; seg_seq[1] = 7'h30; seg_seq[2] = 7'h24; seg_seq[3] = 7'h79;

      minutes = 8'd12; seconds = 6'd34; status = 2'b00;
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("reset_an", 32'(an), 32'hF);
      chk("reset_seg", 32'(seg), 32'h7F);
      chk("reset_dp", 32'(dp), 32'h1);
      chk("reset_digits", 32'(digits), 32'h0);
      cmp_en = 1'b1;
      rst_n = 1'b1;

      // First conversion lands on edge 9 after release.
      cyc(8);
      chk("latency_edge8", 32'(digits), 32'h0);
      cyc(1);
      chk("latency_edge9", 32'(digits), 32'h1234);
      cyc(7);
      for (int i = 0; i < 16; i++) begin
         cyc(1);
         chk("scan_an", 32'(an), 32'(an_seq[i / 4]));
         chk("scan_seg", 32'(seg), 32'(seg_seq[i / 4]));
      end

      // Clamping.
      minutes = 8'd150; seconds = 6'd63;
      cyc(20);
      chk("clamp_digits", 32'(digits), 32'h9959);

      // Decimal point only on digit 2 while running.
      status = 2'b01; minutes = 8'd5; seconds = 6'd7;
      cyc(20);
      chk("run_digits", 32'(digits), 32'h0507);
      dp_low = 0; dp_bad = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1);
         if (dp == 1'b0) dp_low++;
         if ((dp == 1'b0) != (an == 4'hB)) dp_bad++;
      end
      chk("run_dp_low_count", 32'(dp_low), 32'd4);
      chk("run_dp_placement", 32'(dp_bad), 32'd0);
      status = 2'b00;
      cyc(1);
      dp_low = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1);
         if (dp == 1'b0) dp_low++;
      end
      chk("idle_dp_low_count", 32'(dp_low), 32'd0);

      // Pause blink: on phase first, then 32-cycle off and on runs.
      status = 2'b10;
      blanks = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1);
         if (an == 4'hF) blanks++;
      end
      chk("pause_starts_on", 32'(blanks), 32'd0);
      n = 0;
      while (an != 4'hF && n < 100) begin cyc(1); n++; end
      chk("pause_off_found", 32'(n < 100), 32'd1);
      n = 0;
      while (an == 4'hF && n < 100) begin cyc(1); n++; end
      chk("pause_off_len", 32'(n), 32'd32);
      n = 0;
      while (an != 4'hF && n < 100) begin cyc(1); n++; end
      chk("pause_on_len", 32'(n), 32'd32);
      status = 2'b01;
      blanks = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(1);
         if (an == 4'hF) blanks++;
      end
      chk("resume_no_blank", 32'(blanks), 32'd0);

      // Input change during conversion is picked up afterwards.
      status = 2'b00;
      @(negedge clk);
      #2 rst_n = 1'b0;
      minutes = 8'd0; seconds = 6'd0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(3);
      seconds = 6'd1;
      cyc(6);
      chk("midconv_first_done", 32'(digits), 32'h0000);
      cyc(8);
      chk("midconv_edge17", 32'(digits), 32'h0000);
      cyc(1);
      chk("midconv_edge18", 32'(digits), 32'h0001);

      // Reset during a conversion.
      minutes = 8'd45; seconds = 6'd18;
      cyc(3);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_an", 32'(an), 32'hF);
      chk("abort_seg", 32'(seg), 32'h7F);
      chk("abort_dp", 32'(dp), 32'h1);
      chk("abort_digits", 32'(digits), 32'h0);
      minutes = 8'd33; seconds = 6'd21;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(8);
      chk("abort_edge8", 32'(digits), 32'h0);
      cyc(1);
      chk("abort_edge9", 32'(digits), 32'h3321);

      // Randomised traffic against the model.
      for (int s = 0; s < 80; s++) begin
         if ($urandom_range(0, 19) == 0) pulse_reset();
         minutes = 8'($urandom_range(0, 255));
         seconds = 6'($urandom_range(0, 63));
         status  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) status = 2'b10;
         cyc($urandom_range(1, 70));
      end

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
